seg_scan_display: RTL and testbench

Multiplexed 4-digit seven-segment driver clocked by the divided clock. It sits directly downstream of the ripple clock divider: the divider's `div_clock` output drives this block's `clock` port. Each frame latches a 16-bit hex value, then time-multiplexes one digit at a time onto shared active-low segment lines. A blank guard cycle precedes every digit to suppress ghosting.

---
 rtl/seg_pkg.sv | 41 ++++
 rtl/hex_to_7seg.sv | 19 +
 rtl/seg_scan_display.sv | 160 ++++++++++++++++
 tb/tb_seg_scan_display.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : seg_pkg
//  Purpose  : Shared types and constants for the multiplexed seven-segment
//             scan driver: scan phase enum, blank segment pattern, digit
//             count and the active-low hex segment table (gfedcba).
//  Revision : 1.0 - initial release
// ============================================================================
package seg_pkg;

    typedef enum logic [0:0] {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } phase_t;

    localparam int         DIGITS    = 4;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low segment patterns, bit 0 = segment a ... bit 6 = segment g.
    // Entry [0] is the rightmost element of the concatenation.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h0E,  // F
        7'h06,  // E
        7'h21,  // d
        7'h46,  // C
        7'h03,  // b
        7'h08,  // A
        7'h10,  // 9
        7'h00,  // 8
        7'h78,  // 7
        7'h02,  // 6
        7'h12,  // 5
        7'h19,  // 4
        7'h30,  // 3
        7'h24,  // 2
        7'h79,  // 1
        7'h40   // 0
    };

endpackage : seg_pkg
`default_nettype wire

// File: rtl/hex_to_7seg.sv
`default_nettype none
// ============================================================================
//  Module   : hex_to_7seg
//  Purpose  : Combinational nibble to active-low seven-segment decoder.
//  Ports    : nibble [3:0] in  - hex digit
//             seg    [6:0] out - active-low segments, seg[0]=a .. seg[6]=g
//  Revision : 1.0 - initial release
// ============================================================================
module hex_to_7seg
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = SEG_TABLE[nibble];

endmodule : hex_to_7seg
`default_nettype wire

// File: rtl/seg_scan_display.sv
`default_nettype none
// ============================================================================
//  Module   : seg_scan_display
//  Purpose  : Multiplexed 4-digit seven-segment scan driver. Latches a 16-bit
//             hex value once per frame and shows one digit at a time, each
//             digit preceded by a single blank guard cycle.
//  Params   : HOLD_CYCLES (1..15) - SHOW cycles per digit
//  Ports    : clock        in   scan clock (divided clock), rising edge
//             reset        in   asynchronous, active-high
//             enable       in   scan enable, low blanks the display
//             value [15:0] in   hex digits, value[3:0] is digit 0 (rightmost)
//             dp_in [3:0]  in   decimal points, active-high, bit n = digit n
//             anode [3:0]  out  digit select, active-low
//             seg   [6:0]  out  segments, active-low, seg[0]=a .. seg[6]=g
//             dp           out  decimal point, active-low
//             frame_done   out  one-cycle pulse on the last SHOW of digit 3
//  Options  : define SEG_LEADING_ZERO_BLANK_EN to blank leading zero digits
//             (digits 3..1); digit 0 is always decoded.
//  Revision : 1.0 - initial release
// ============================================================================
module seg_scan_display
    import seg_pkg::*;
#(
    parameter int HOLD_CYCLES = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic [15:0] value,
    input  logic [3:0]  dp_in,
    output logic [3:0]  anode,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_done
);

    localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYCLES - 1);

    phase_t      phase, phase_nx;
    logic [1:0]  digit, digit_nx;
    logic [3:0]  hold, hold_nx;
    // Set after reset or while disabled: the next enabled edge is the
    // BLANK(0) entry edge and latches a fresh value.
    logic        restart, restart_nx;
    logic        latch;
    logic [15:0] value_q;
    logic [3:0]  dp_q;

    logic [3:0]  nibble;
    logic [6:0]  dec_seg;
    logic        lz_blank;
    logic        show_nx;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        phase_nx   = phase;
        digit_nx   = digit;
        hold_nx    = hold;
        restart_nx = restart;
        latch      = 1'b0;
        if (!enable) begin
            phase_nx   = BLANK;
            digit_nx   = 2'd0;
            hold_nx    = 4'd0;
            restart_nx = 1'b1;
        end else if (restart) begin
            phase_nx   = BLANK;
            digit_nx   = 2'd0;
            hold_nx    = 4'd0;
            restart_nx = 1'b0;
            latch      = 1'b1;
        end else if (phase == BLANK) begin
            phase_nx = SHOW;
            hold_nx  = 4'd0;
        end else if (hold == HOLD_LAST) begin
            phase_nx = BLANK;
            digit_nx = digit + 2'd1;
            hold_nx  = 4'd0;
            latch    = (digit == 2'd3);
        end else begin
            hold_nx = hold + 4'd1;
        end
    end

    // ------------------------------------------------------------------
    // Output decode for the state being entered; outputs are registered
    // so they line up with the state they describe.
    // ------------------------------------------------------------------
    always_comb begin
        case (digit_nx)
            2'd0:    nibble = value_q[3:0];
            2'd1:    nibble = value_q[7:4];
            2'd2:    nibble = value_q[11:8];
            default: nibble = value_q[15:12];
        endcase
    end

    hex_to_7seg u_dec (
        .nibble (nibble),
        .seg    (dec_seg)
    );

`ifdef SEG_LEADING_ZERO_BLANK_EN
    // A digit is a leading zero when it and every more-significant nibble
    // are zero.
    always_comb begin
        case (digit_nx)
            2'd3:    lz_blank = (value_q[15:12] == 4'h0);
            2'd2:    lz_blank = (value_q[15:8]  == 8'h00);
            2'd1:    lz_blank = (value_q[15:4]  == 12'h000);
            default: lz_blank = 1'b0;
        endcase
    end
`else
    assign lz_blank = 1'b0;
`endif

    assign show_nx = (phase_nx == SHOW);

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            phase      <= BLANK;
            digit      <= 2'd0;
            hold       <= 4'd0;
            restart    <= 1'b1;
            value_q    <= 16'h0000;
            dp_q       <= 4'b0000;
            anode      <= 4'b1111;
            seg        <= SEG_BLANK;
            dp         <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            phase   <= phase_nx;
            digit   <= digit_nx;
            hold    <= hold_nx;
            restart <= restart_nx;
            if (latch) begin
                value_q <= value;
                dp_q    <= dp_in;
            end
            if (show_nx) begin
                anode <= ~(4'b0001 << digit_nx);
                seg   <= lz_blank ? SEG_BLANK : dec_seg;
                dp    <= ~dp_q[digit_nx];
            end else begin
                anode <= 4'b1111;
                seg   <= SEG_BLANK;
                dp    <= 1'b1;
            end
            frame_done <= show_nx && (digit_nx == 2'd3) && (hold_nx == HOLD_LAST);
        end
    end

endmodule : seg_scan_display
`default_nettype wire

// File: tb/tb_seg_scan_display.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seg_scan_display
//  Purpose  : Directed self-checking bench for seg_scan_display. One instance
//             uses HOLD_CYCLES=1, a second uses HOLD_CYCLES=3. Expected
//             {anode, seg, dp, frame_done} values are hand-computed.
//  Options  : honours SEG_LEADING_ZERO_BLANK_EN for leading-zero expectations
//  Revision : 1.0 - initial release
// ============================================================================
module tb_seg_scan_display;

    logic        clock;
    logic        reset;
    logic        enable;
    logic [15:0] value;
    logic [3:0]  dp_in;

    logic [3:0]  anode,  anode3;
    logic [6:0]  seg,    seg3;
    logic        dp,     dp3;
    logic        fd,     fd3;

    int total = 0;
    int bad   = 0;

`ifdef SEG_LEADING_ZERO_BLANK_EN
    localparam logic [6:0] LZ_SEG = 7'h7F;
`else
    localparam logic [6:0] LZ_SEG = 7'h40;
`endif

    seg_scan_display #(.HOLD_CYCLES(1)) dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .value      (value),
        .dp_in      (dp_in),
        .anode      (anode),
        .seg        (seg),
        .dp         (dp),
        .frame_done (fd)
    );

    seg_scan_display #(.HOLD_CYCLES(3)) dut3 (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .value      (value),
        .dp_in      (dp_in),
        .anode      (anode3),
        .seg        (seg3),
        .dp         (dp3),
        .frame_done (fd3)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", tag, got, exp);
        end
    endtask

    // Advance one edge and check the HOLD_CYCLES=1 instance.
    task automatic cyc(input string tag, input logic [3:0] an, input logic [6:0] sg,
                       input logic d, input logic f);
        @(posedge clock);
        #1;
        chk(tag, {19'd0, anode, seg, dp, fd}, {19'd0, an, sg, d, f});
    endtask

    task automatic bl(input string tag);
        cyc(tag, 4'b1111, 7'h7F, 1'b1, 1'b0);
    endtask

    initial begin
        int fd_count;
        int fd_edge;
        logic [6:0] exp_seg [4];
        exp_seg[0] = 7'h19;  // 4
        exp_seg[1] = 7'h30;  // 3
        exp_seg[2] = 7'h24;  // 2
        exp_seg[3] = 7'h79;  // 1

        reset  = 1'b0;
        enable = 1'b1;
        value  = 16'h1234;
        dp_in  = 4'b0010;
        #2 reset = 1'b1;
        #1;
        chk("reset_state", {19'd0, anode, seg, dp, fd}, {19'd0, 4'b1111, 7'h7F, 1'b1, 1'b0});
        chk("reset_state3", {19'd0, anode3, seg3, dp3, fd3}, {19'd0, 4'b1111, 7'h7F, 1'b1, 1'b0});
        @(posedge clock); @(posedge clock);
        #1 reset = 1'b0;

        // Basic frame: 1234, dp on digit 1
        bl("f1_b0");  cyc("f1_d0", 4'b1110, 7'h19, 1'b1, 1'b0);
        bl("f1_b1");  cyc("f1_d1", 4'b1101, 7'h30, 1'b0, 1'b0);
        bl("f1_b2");  cyc("f1_d2", 4'b1011, 7'h24, 1'b1, 1'b0);
        bl("f1_b3");  cyc("f1_d3", 4'b0111, 7'h79, 1'b1, 1'b1);

        // No tearing: change value during SHOW(1)
        bl("f2_b0");  cyc("f2_d0", 4'b1110, 7'h19, 1'b1, 1'b0);
        bl("f2_b1");  cyc("f2_d1", 4'b1101, 7'h30, 1'b0, 1'b0);
        value = 16'hFFFF; dp_in = 4'b0000;
        bl("f2_b2");  cyc("f2_d2", 4'b1011, 7'h24, 1'b1, 1'b0);
        bl("f2_b3");  cyc("f2_d3", 4'b0111, 7'h79, 1'b1, 1'b1);
        bl("f3_b0");  cyc("f3_d0", 4'b1110, 7'h0E, 1'b1, 1'b0);
        bl("f3_b1");  cyc("f3_d1", 4'b1101, 7'h0E, 1'b1, 1'b0);
        bl("f3_b2");  cyc("f3_d2", 4'b1011, 7'h0E, 1'b1, 1'b0);
        bl("f3_b3");  cyc("f3_d3", 4'b0111, 7'h0E, 1'b1, 1'b1);

        // Enable dropped during SHOW(1), then restored with a new value
        bl("f4_b0");  cyc("f4_d0", 4'b1110, 7'h0E, 1'b1, 1'b0);
        bl("f4_b1");  cyc("f4_d1", 4'b1101, 7'h0E, 1'b1, 1'b0);
        enable = 1'b0; value = 16'h5678; dp_in = 4'b0001;
        bl("en_off0"); bl("en_off1");
        enable = 1'b1;
        bl("f5_b0");  cyc("f5_d0", 4'b1110, 7'h00, 1'b0, 1'b0);
        bl("f5_b1");  cyc("f5_d1", 4'b1101, 7'h78, 1'b1, 1'b0);
        bl("f5_b2");  cyc("f5_d2", 4'b1011, 7'h02, 1'b1, 1'b0);
        bl("f5_b3");  cyc("f5_d3", 4'b0111, 7'h12, 1'b1, 1'b1);

        // Leading zeros
        value = 16'h0008; dp_in = 4'b0000;
        bl("lz_b0");  cyc("lz_d0", 4'b1110, 7'h00, 1'b1, 1'b0);
        bl("lz_b1");  cyc("lz_d1", 4'b1101, LZ_SEG, 1'b1, 1'b0);
        bl("lz_b2");  cyc("lz_d2", 4'b1011, LZ_SEG, 1'b1, 1'b0);
        bl("lz_b3");  cyc("lz_d3", 4'b0111, LZ_SEG, 1'b1, 1'b1);

        // Enable falling at the last SHOW(3) edge: blanking wins, no pulse
        bl("sim_b0"); cyc("sim_d0", 4'b1110, 7'h00, 1'b1, 1'b0);
        bl("sim_b1"); cyc("sim_d1", 4'b1101, LZ_SEG, 1'b1, 1'b0);
        bl("sim_b2"); cyc("sim_d2", 4'b1011, LZ_SEG, 1'b1, 1'b0);
        bl("sim_b3");
        enable = 1'b0;
        bl("sim_last");
        value = 16'h1234; dp_in = 4'b0010; enable = 1'b1;

        // Asynchronous reset during SHOW(2)
        bl("r_b0");   cyc("r_d0", 4'b1110, 7'h19, 1'b1, 1'b0);
        bl("r_b1");   cyc("r_d1", 4'b1101, 7'h30, 1'b0, 1'b0);
        bl("r_b2");   cyc("r_d2", 4'b1011, 7'h24, 1'b1, 1'b0);
        #2 reset = 1'b1;
        #1;
        chk("reset_mid", {19'd0, anode, seg, dp, fd}, {19'd0, 4'b1111, 7'h7F, 1'b1, 1'b0});
        @(posedge clock);
        #1 reset = 1'b0;
        bl("rr_b0");  cyc("rr_d0", 4'b1110, 7'h19, 1'b1, 1'b0);
        bl("rr_b1");  cyc("rr_d1", 4'b1101, 7'h30, 1'b0, 1'b0);

        // HOLD_CYCLES=3 instance: 16-cycle frame, 3 cycles per digit
        @(negedge clock) reset = 1'b1;
        dp_in = 4'b0000;
        @(posedge clock);
        #1 reset = 1'b0;
        fd_count = 0;
        fd_edge  = 0;
        for (int c = 1; c <= 17; c++) begin
            int grp;
            int sub;
            logic [3:0] ea;
            logic [6:0] es;
            logic       ed;
            @(posedge clock);
            #1;
            grp = (c - 1) / 4;
            sub = (c - 1) % 4;
            if (sub == 0 || grp > 3) begin
                ea = 4'b1111; es = 7'h7F;
            end else begin
                ea = ~(4'b0001 << grp); es = exp_seg[grp];
            end
            ed = (c == 16);
            if (fd3) begin
                fd_count++;
                fd_edge = c;
            end
            chk($sformatf("h3_c%0d", c), {19'd0, anode3, seg3, dp3, fd3},
                {19'd0, ea, es, 1'b1, ed});
        end
        chk("h3_fd_width", fd_count, 1);
        chk("h3_fd_edge", fd_edge, 16);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_seg_scan_display
`default_nettype wire
